// File: rtl/montgomery_mul_seq.sv
// Multi-cycle Montgomery engine: result = T * 2^-k mod m, with T = a*b (multiply) or {b,a} (reduce).
// The exponent k is a run-time input, so one instance serves several moduli.
module montgomery_mul_seq #(
  parameter int WIDTH = 64,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] minv_i,
  input  logic [KW-1:0]    k_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_QCOMP,
    S_TCOMP,
    S_CORR
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   w_accept;
  logic   w_exit;

  logic               r_mode;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_minv;
  logic [KW-1:0]      r_k;
  logic [2*WIDTH-1:0] r_tFull;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_tRed;
  logic               r_errPend;
  logic               r_finish;
  logic               r_err;
  logic [WIDTH-1:0]   r_result;

  logic [2*WIDTH-1:0] w_aExt;
  logic [2*WIDTH-1:0] w_bExt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_tFull;
  logic [2*WIDTH-1:0] w_qExt;
  logic [2*WIDTH-1:0] w_mExt;
  logic [2*WIDTH-1:0] w_qm;
  logic [2*WIDTH:0]   w_sum;
  logic [WIDTH-1:0]   w_kMask;
  logic [WIDTH-1:0]   w_qProd;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH:0]     w_tRed;
  logic [WIDTH:0]     w_mWide;
  logic [WIDTH-1:0]   w_corr;
  logic               w_paramErr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept    = 1'b1;
          w_nextState = S_MUL;
        end
      end
      S_MUL:   w_nextState = S_QCOMP;
      S_QCOMP: w_nextState = S_TCOMP;
      S_TCOMP: w_nextState = S_CORR;
      S_CORR: begin
        w_exit      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_aExt     = {{WIDTH{1'b0}}, r_a};
  assign w_bExt     = {{WIDTH{1'b0}}, r_b};
  assign w_prod     = w_aExt * w_bExt;
  assign w_tFull    = r_mode ? {r_b, r_a} : w_prod;
  assign w_paramErr = (r_k == '0) || (r_k > KW'(WIDTH)) || !r_m[0];

  // Mask of the low k bits; k == WIDTH must not overflow the shift.
  always_comb begin
    w_kMask = '1;
    if (r_k < KW'(WIDTH)) begin
      w_kMask = (WIDTH'(1) << r_k) - WIDTH'(1);
    end
  end

  assign w_qProd = (r_tFull[WIDTH-1:0] & w_kMask) * r_minv;
  assign w_q     = w_qProd & w_kMask;

  // T + q*m needs one carry bit beyond 2*WIDTH before the shift by k.
  assign w_qExt  = {{WIDTH{1'b0}}, r_q};
  assign w_mExt  = {{WIDTH{1'b0}}, r_m};
  assign w_qm    = w_qExt * w_mExt;
  assign w_sum   = {1'b0, r_tFull} + {1'b0, w_qm};
  assign w_tRed  = (WIDTH+1)'(w_sum >> r_k);

  assign w_mWide = {1'b0, r_m};
  assign w_corr  = (r_tRed >= w_mWide) ? WIDTH'(r_tRed - w_mWide) : WIDTH'(r_tRed);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_minv    <= '0;
      r_k       <= '0;
      r_tFull   <= '0;
      r_q       <= '0;
      r_tRed    <= '0;
      r_errPend <= 1'b0;
      r_finish  <= 1'b0;
      r_err     <= 1'b0;
      r_result  <= '0;
    end else begin
      r_finish <= w_exit;
      if (w_accept) begin
        r_mode <= mode_i;
        r_a    <= a_i;
        r_b    <= b_i;
        r_m    <= m_i;
        r_minv <= minv_i;
        r_k    <= k_i;
        r_err  <= 1'b0;
      end
      if (r_state == S_MUL) begin
        r_tFull   <= w_tFull;
        r_errPend <= w_paramErr;
      end
      if (r_state == S_QCOMP) begin
        r_q <= w_q;
      end
      if (r_state == S_TCOMP) begin
        r_tRed <= w_tRed;
      end
      // A parameter error still walks the pipeline so latency stays fixed.
      if (w_exit) begin
        r_result <= r_errPend ? '0 : w_corr;
        r_err    <= r_errPend;
      end
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign finish_o = r_finish;
  assign err_o    = r_err;
  assign result_o = r_result;

endmodule

// File: tb/tb_montgomery_mul_seq.sv
// Directed and randomised checks of montgomery_mul_seq at WIDTH=64 using immediate assertions.
module tb_montgomery_mul_seq;

  localparam int WIDTH = 64;
  localparam int KW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] m = '0;
  logic [WIDTH-1:0] minv = '0;
  logic [KW-1:0]    k = '0;
  logic             busy;
  logic             finish;
  logic             err;
  logic [WIDTH-1:0] result;

  int nCmp = 0;
  int nFail = 0;
  int covSub = 0;
  int covNoSub = 0;

  montgomery_mul_seq #(.WIDTH(WIDTH), .KW(KW)) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .start_i (start),
    .mode_i  (mode),
    .a_i     (a),
    .b_i     (b),
    .m_i     (m),
    .minv_i  (minv),
    .k_i     (k),
    .busy_o  (busy),
    .finish_o(finish),
    .err_o   (err),
    .result_o(result)
  );

  always #5 clk = ~clk;

  // Tracks which way the final conditional subtraction went on valid operations.
  always @(posedge clk) begin
    if (dut.w_exit && !dut.r_errPend) begin
      if (dut.r_tRed >= {1'b0, dut.r_m}) covSub++;
      else covNoSub++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic md, input logic [63:0] av, input logic [63:0] bv,
                               input logic [63:0] mv, input logic [63:0] iv, input logic [KW-1:0] kv);
    @(negedge clk);
    mode  = md;
    a     = av;
    b     = bv;
    m     = mv;
    minv  = iv;
    k     = kv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitFinish(output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic doOp(input string tag, input logic md, input logic [63:0] av, input logic [63:0] bv,
                      input logic [63:0] mv, input logic [63:0] iv, input logic [KW-1:0] kv,
                      input logic [63:0] expRes, input logic expErr);
    int lat;
    applyStimulus(md, av, bv, mv, iv, kv);
    waitFinish(lat);
    checkOutput({tag, ".lat"}, 128'(lat), 128'(4));
    checkOutput({tag, ".res"}, 128'(result), 128'(expRes));
    checkOutput({tag, ".err"}, 128'(err), 128'(expErr));
    checkOutput({tag, ".busy"}, 128'(busy), 128'(0));
  endtask

  function automatic int bitlen(input logic [63:0] v);
    int n = 0;
    for (int i = 0; i < 64; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Newton iteration for m^-1 mod 2^64, then negated and cut to k bits.
  function automatic logic [63:0] negInv(input logic [63:0] mv, input int kv);
    logic [63:0] x;
    logic [63:0] mask;
    x = mv;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - mv * x);
    mask = (kv >= 64) ? '1 : ((64'd1 << kv) - 64'd1);
    return (~x + 64'd1) & mask;
  endfunction

  initial begin
    int          lat;
    int          nFin;
    int          first;
    int          second;
    int          kk;
    logic        md;
    logic [63:0] rm;
    logic [63:0] iv;
    logic [63:0] av;
    logic [63:0] bv;
    logic [128:0] bound;
    logic [128:0] rt;
    logic [128:0] lhs;
    logic [128:0] rhs;

    #1;
    checkOutput("reset.busy", 128'(busy), 128'(0));
    checkOutput("reset.finish", 128'(finish), 128'(0));
    checkOutput("reset.err", 128'(err), 128'(0));
    checkOutput("reset.result", 128'(result), 128'(0));
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(1'b1, 64'h1000, 64'h0, 64'hD01, 64'hCFF, 7'd12);
    checkOutput("red.busy", 128'(busy), 128'(1));
    waitFinish(lat);
    checkOutput("red.lat", 128'(lat), 128'(4));
    checkOutput("red.res", 128'(result), 128'(1));
    checkOutput("red.err", 128'(err), 128'(0));

    doOp("mul0", 1'b0, 64'h0, 64'h123, 64'hD01, 64'hCFF, 7'd12, 64'h0, 1'b0);
    doOp("mul5", 1'b0, 64'h2FF, 64'h5, 64'hD01, 64'hCFF, 7'd12, 64'h5, 1'b0);
    doOp("mulR", 1'b0, 64'h2FF, 64'h2FF, 64'hD01, 64'hCFF, 7'd12, 64'h2FF, 1'b0);

    doOp("errEven", 1'b0, 64'h2FF, 64'h5, 64'hD00, 64'hCFF, 7'd12, 64'h0, 1'b1);
    doOp("errK0", 1'b0, 64'h2FF, 64'h5, 64'hD01, 64'hCFF, 7'd0, 64'h0, 1'b1);
    doOp("errK65", 1'b0, 64'h2FF, 64'h5, 64'hD01, 64'hCFF, 7'd65, 64'h0, 1'b1);

    applyStimulus(1'b0, 64'h2FF, 64'h5, 64'hD01, 64'hCFF, 7'd12);
    checkOutput("recover.errClr", 128'(err), 128'(0));
    checkOutput("recover.busy", 128'(busy), 128'(1));
    waitFinish(lat);
    checkOutput("recover.lat", 128'(lat), 128'(4));
    checkOutput("recover.res", 128'(result), 128'(5));

    // start held high: accepts at edges 0,5,10,15 give finishes at 4,9,14.
    @(negedge clk);
    mode = 1'b1; a = 64'h1000; b = 64'h0; m = 64'hD01; minv = 64'hCFF; k = 7'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    nFin = 0; first = -1; second = -1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        nFin++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("b2b.count", 128'(nFin), 128'(3));
    checkOutput("b2b.first", 128'(first), 128'(4));
    checkOutput("b2b.second", 128'(second), 128'(9));
    checkOutput("b2b.res", 128'(result), 128'(1));

    doOp("pre", 1'b0, 64'h2FF, 64'h2FF, 64'hD01, 64'hCFF, 7'd12, 64'h2FF, 1'b0);
    applyStimulus(1'b1, 64'h1000, 64'h0, 64'hD01, 64'hCFF, 7'd12);
    @(posedge clk);
    #1;
    @(negedge clk);
    mode = 1'b0; a = 64'h2FF; b = 64'h5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignore.hold", 128'(result), 128'(64'h2FF));
    nFin = 0; first = -1;
    for (int c = 3; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        nFin++;
        if (first < 0) first = c;
      end
    end
    checkOutput("ignore.count", 128'(nFin), 128'(1));
    checkOutput("ignore.lat", 128'(first), 128'(4));
    checkOutput("ignore.res", 128'(result), 128'(1));

    applyStimulus(1'b0, 64'h2FF, 64'h5, 64'hD01, 64'hCFF, 7'd12);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst.busy", 128'(busy), 128'(0));
    checkOutput("rst.finish", 128'(finish), 128'(0));
    checkOutput("rst.err", 128'(err), 128'(0));
    checkOutput("rst.result", 128'(result), 128'(0));
    nFin = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (finish) nFin++;
    end
    checkOutput("rst.noFinish", 128'(nFin), 128'(0));
    @(negedge clk);
    rstN = 1'b1;
    doOp("postRst", 1'b1, 64'h1000, 64'h0, 64'hD01, 64'hCFF, 7'd12, 64'h1, 1'b0);

    // Random vectors: result must be below m and satisfy r*2^k == T (mod m).
    for (int i = 0; i < 10000; i++) begin
      rm = {$urandom, $urandom} >> $urandom_range(0, 62);
      rm[0] = 1'b1;
      kk = bitlen(rm);
      iv = negInv(rm, kk);
      md = 1'($urandom_range(0, 1));
      if (md) begin
        bound = {65'b0, rm} << kk;
        rt = {1'b0, $urandom, $urandom, $urandom, $urandom} % bound;
        av = rt[63:0];
        bv = rt[127:64];
      end else begin
        av = {$urandom, $urandom} % rm;
        bv = {$urandom, $urandom} % rm;
        rt = {65'b0, av} * {65'b0, bv};
      end
      applyStimulus(md, av, bv, rm, iv, KW'(kk));
      waitFinish(lat);
      checkOutput("rnd.lat", 128'(lat), 128'(4));
      checkOutput("rnd.err", 128'(err), 128'(0));
      checkOutput("rnd.range", 128'(result < rm), 128'(1));
      lhs = ({65'b0, result} << kk) % {65'b0, rm};
      rhs = rt % {65'b0, rm};
      checkOutput("rnd.cong", lhs[127:0], rhs[127:0]);
    end

    checkOutput("cov.sub", 128'(covSub > 0), 128'(1));
    checkOutput("cov.noSub", 128'(covNoSub > 0), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
